// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Purpose  : 8N1 UART receiver with oversampling tick, 2-flop RX synchroniser
//            and a one-deep valid/ack holding register with overrun/framing flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
  parameter int CLK_HZ   = 50000000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16,
  parameter int TICK_DIV = CLK_HZ / (BAUD * OVS)
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       rx,
  input  logic       data_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int c_DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_OS_W  = $clog2(OVS);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
  localparam logic [c_OS_W-1:0]  c_OS_MID   = c_OS_W'(OVS / 2 - 1);
  localparam logic [c_OS_W-1:0]  c_OS_LAST  = c_OS_W'(OVS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_rx_meta, r_rx_s;
  logic [c_DIV_W-1:0] r_div_cnt;
  logic               w_tick;
  logic [c_OS_W-1:0]  r_os_cnt, w_os_nxt, w_os_inc;
  logic [2:0]         r_bit_cnt, w_bit_nxt;
  logic [7:0]         r_sh, w_sh_nxt;
  logic               w_load, w_fe_nxt;
  logic [7:0]         r_data_out;
  logic               r_data_valid, r_overrun, r_frame_err;

  assign w_tick   = (r_div_cnt == c_DIV_LAST);
  assign w_os_inc = r_os_cnt + 1'b1;

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_os_nxt    = r_os_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_sh_nxt    = r_sh;
    w_load      = 1'b0;
    w_fe_nxt    = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            w_state_nxt = S_START;
            w_os_nxt    = '0;
          end
        end
        S_START: begin
          // Re-check lands in the middle of the start bit.
          if (w_os_inc == c_OS_MID) begin
            w_os_nxt    = '0;
            w_bit_nxt   = '0;
            w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
          end else begin
            w_os_nxt = w_os_inc;
          end
        end
        S_DATA: begin
          if (r_os_cnt == c_OS_LAST) begin
            w_os_nxt = '0;
            w_sh_nxt = {r_rx_s, r_sh[7:1]};
            if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
            else                   w_bit_nxt   = r_bit_cnt + 1'b1;
          end else begin
            w_os_nxt = w_os_inc;
          end
        end
        S_STOP: begin
          if (r_os_cnt == c_OS_LAST) begin
            w_os_nxt = '0;
            if (r_rx_s) begin
              w_load      = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_fe_nxt    = 1'b1;
              w_state_nxt = S_BREAK;
            end
          end else begin
            w_os_nxt = w_os_inc;
          end
        end
        S_BREAK: begin
          if (r_rx_s) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_rx_meta    <= 1'b1;
      r_rx_s       <= 1'b1;
      r_div_cnt    <= '0;
      r_os_cnt     <= '0;
      r_bit_cnt    <= '0;
      r_sh         <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_meta   <= rx;
      r_rx_s      <= r_rx_meta;
      r_div_cnt   <= w_tick ? '0 : r_div_cnt + 1'b1;
      r_os_cnt    <= w_os_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_sh        <= w_sh_nxt;
      r_frame_err <= w_fe_nxt;
      // A load beats a coincident ack; the ack still clears any old overrun.
      if (w_load) begin
        r_data_out   <= r_sh;
        r_data_valid <= 1'b1;
        r_overrun    <= data_ack ? 1'b0 : (r_overrun | r_data_valid);
      end else if (data_ack) begin
        r_data_valid <= 1'b0;
        r_overrun    <= 1'b0;
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Purpose  : Self-checking bench for uart_rx_ctrl using a sample-schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

  localparam int c_CLK_HZ = 614400;
  localparam int c_BAUD   = 9600;
  localparam int c_OVS    = 16;
  localparam int c_TD     = c_CLK_HZ / (c_BAUD * c_OVS);
  localparam int c_BIT    = c_OVS * c_TD;
  localparam int c_PER    = c_BIT * 100;
  localparam int c_H      = c_OVS / 2 - 1;
  localparam int c_STOP_K = c_H + 9 * c_OVS;

  logic       clk_50  = 1'b0;
  logic       rst     = 1'b1;
  logic       rx      = 1'b1;
  logic       ack_man = 1'b0;
  logic       ack_auto = 1'b0;
  logic       auto_en = 1'b0;
  logic       data_ack;
  logic [7:0] data_out;
  logic       data_valid, overrun, frame_err, busy;

  assign data_ack = ack_man | ack_auto;

  always #10 clk_50 = ~clk_50;

  uart_rx_ctrl #(
    .CLK_HZ(c_CLK_HZ),
    .BAUD  (c_BAUD),
    .OVS   (c_OVS)
  ) dut (
    .clk_50    (clk_50),
    .rst       (rst),
    .rx        (rx),
    .data_ack  (data_ack),
    .data_out  (data_out),
    .data_valid(data_valid),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Model: after a start is seen on a tick, every later sample lands a fixed
  // number of ticks later, so the frame is decoded from tick index arithmetic.
  int         m_n, m_mode, m_t0, m_k, m_j, m_load_edge;
  logic       m_d1, m_d2, m_rs, m_tick, m_load;
  logic [7:0] m_byte;
  logic [7:0] e_data;
  logic       e_valid, e_ov, e_fe;

  always @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      m_n = 0; m_mode = 0; m_t0 = 0; m_load_edge = -1;
      m_d1 = 1'b1; m_d2 = 1'b1; m_byte = 8'h00;
      e_data = 8'h00; e_valid = 1'b0; e_ov = 1'b0; e_fe = 1'b0;
    end else begin
      m_rs   = m_d2;
      m_d2   = m_d1;
      m_d1   = rx;
      m_tick = ((m_n % c_TD) == c_TD - 1);
      m_load = 1'b0;
      e_fe   = 1'b0;
      if (m_tick) begin
        if (m_mode == 0) begin
          if (!m_rs) begin
            m_mode = 1; m_t0 = m_n; m_load_edge = m_n + c_STOP_K * c_TD;
          end
        end else if (m_mode == 1) begin
          m_k = (m_n - m_t0) / c_TD;
          if (m_k == c_H) begin
            if (m_rs) m_mode = 0;
          end else if (m_k > c_H && ((m_k - c_H) % c_OVS) == 0) begin
            m_j = (m_k - c_H) / c_OVS;
            if (m_j <= 8) m_byte[m_j-1] = m_rs;
            else if (m_rs) begin m_load = 1'b1; m_mode = 0; end
            else begin e_fe = 1'b1; m_mode = 2; end
          end
        end else if (m_rs) begin
          m_mode = 0;
        end
      end
      if (m_load) begin
        if (data_ack) e_ov = 1'b0;
        else if (e_valid) e_ov = 1'b1;
        e_valid = 1'b1;
        e_data  = m_byte;
      end else if (data_ack) begin
        e_valid = 1'b0;
        e_ov    = 1'b0;
      end
      m_n++;
    end
  end

  always @(negedge clk_50) begin
    if (!rst)
      check("cycle_outputs", {20'd0, busy, frame_err, overrun, data_valid, data_out},
            {20'd0, (m_mode != 0), e_fe, e_ov, e_valid, e_data});
  end

  int   cyc = 0;
  int   rise_cyc = 0;
  int   fe_cnt = 0;
  int   busy_run = 0;
  int   busy_max = 0;
  logic prev_valid = 1'b0;
  logic [7:0] rxq[$];

  always @(posedge clk_50) cyc++;

  always @(negedge clk_50) begin
    if (frame_err) fe_cnt++;
    if (busy) begin
      busy_run++;
      if (busy_run > busy_max) busy_max = busy_run;
    end else begin
      busy_run = 0;
    end
    if (data_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = data_valid;
    if (auto_en && data_valid && !ack_auto) begin
      rxq.push_back(data_out);
      ack_auto = 1'b1;
    end else begin
      ack_auto = 1'b0;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int per_cc);
    logic [9:0] f;
    int c;
    f = {stop_bit, b, 1'b0};
    c = 0;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      while (c < ((i + 1) * per_cc) / 100) begin
        @(negedge clk_50);
        c++;
      end
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk_50);
  endtask

  task automatic pulse_ack();
    ack_man = 1'b1;
    @(negedge clk_50);
    ack_man = 1'b0;
    @(negedge clk_50);
  endtask

  task automatic ack_on_load();
    int w;
    repeat (c_BIT) @(negedge clk_50);
    w = 0;
    while (m_n != m_load_edge && w < 2000) begin
      @(negedge clk_50);
      w++;
    end
    if (w >= 2000) begin
      check("ack_on_load_timeout", 32'd0, 32'd1);
    end else begin
      ack_man = 1'b1;
      @(negedge clk_50);
      ack_man = 1'b0;
    end
  endtask

  logic [7:0] exp_stream [6] = '{8'h00, 8'hFF, 8'h55, 8'h00, 8'hFF, 8'h55};
  int         rates [2] = '{6275, 6531};
  logic [7:0] part;
  int         start_cyc, fe0;

  initial begin
    #1;
    check("reset_outputs", {20'd0, busy, frame_err, overrun, data_valid, data_out}, 32'd0);
    repeat (3) @(negedge clk_50);
    rst = 1'b0;
    idle(2 * c_BIT);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(data_valid), 32'd0);

    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, c_PER);
    check("a5_data", 32'(data_out), 32'hA5);
    check("a5_valid", 32'(data_valid), 32'd1);
    check("a5_fe", 32'(fe_cnt), 32'd0);
    check("a5_latency", 32'((rise_cyc - start_cyc) >= 607 && (rise_cyc - start_cyc) <= 610), 32'd1);
    pulse_ack();
    check("a5_acked", 32'(data_valid), 32'd0);

    idle(c_BIT);
    busy_max = 0;
    rx = 1'b0;
    repeat (c_BIT / 4) @(negedge clk_50);
    idle(2 * c_BIT);
    check("glitch_valid", 32'(data_valid), 32'd0);
    check("glitch_busy_window", 32'(busy_max > 0 && busy_max < 38), 32'd1);
    check("glitch_busy_end", 32'(busy), 32'd0);

    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, c_PER);
    repeat (3 * c_BIT) @(negedge clk_50);
    check("framing_pulse_once", 32'(fe_cnt - fe0), 32'd1);
    check("framing_no_valid", 32'(data_valid), 32'd0);
    idle(c_BIT);
    send_frame(8'h81, 1'b1, c_PER);
    check("after_break_data", 32'(data_out), 32'h81);
    check("after_break_valid", 32'(data_valid), 32'd1);
    pulse_ack();

    idle(c_BIT);
    send_frame(8'h11, 1'b1, c_PER);
    send_frame(8'h22, 1'b1, c_PER);
    check("overrun_data", 32'(data_out), 32'h22);
    check("overrun_flag", 32'(overrun), 32'd1);
    pulse_ack();
    check("overrun_ack_valid", 32'(data_valid), 32'd0);
    check("overrun_ack_flag", 32'(overrun), 32'd0);

    idle(c_BIT);
    send_frame(8'h11, 1'b1, c_PER);
    check("simul_pre_valid", 32'(data_valid), 32'd1);
    fork
      send_frame(8'h22, 1'b1, c_PER);
      ack_on_load();
    join
    check("simul_valid", 32'(data_valid), 32'd1);
    check("simul_overrun", 32'(overrun), 32'd0);
    check("simul_data", 32'(data_out), 32'h22);
    pulse_ack();

    idle(c_BIT);
    rxq.delete();
    auto_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int b = 0; b < 3; b++) send_frame(exp_stream[b], 1'b1, rates[r]);
      idle(c_BIT);
    end
    auto_en = 1'b0;
    check("rate_count", 32'(rxq.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < rxq.size()) check("rate_byte", 32'(rxq[i]), 32'(exp_stream[i]));
    check("rate_overrun", 32'(overrun), 32'd0);

    // Partial frame 0x5A cut by reset during data bit 4.
    idle(c_BIT);
    part = 8'h5A;
    rx = 1'b0;
    repeat (c_BIT) @(negedge clk_50);
    for (int i = 0; i < 4; i++) begin
      rx = part[i];
      repeat (c_BIT) @(negedge clk_50);
    end
    rx = part[4];
    repeat (c_BIT / 2) @(negedge clk_50);
    #5 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_outputs", {24'd0, data_out}, 32'd0);
    check("midrst_valid", 32'(data_valid), 32'd0);
    @(negedge clk_50);
    rx = 1'b1;
    repeat (2) @(negedge clk_50);
    rst = 1'b0;
    idle(2 * c_BIT);
    check("midrst_no_output", 32'(data_valid), 32'd0);
    send_frame(8'hC3, 1'b1, c_PER);
    check("c3_data", 32'(data_out), 32'hC3);
    check("c3_valid", 32'(data_valid), 32'd1);
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
